// File: rtl/port0_serial_tx.sv
// port0_serial_tx: frames the 16-bit Port0 word as start bit, 16 data bits LSB first, stop bit on one wire
module port0_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic          tc;
  assign tc   = baud_q == BAUD_LAST;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  // state and datapath registers; reset aborts any frame without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // next state: every phase ends on the baud terminal count, DATA after its 16th bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = START;
      START:   if (tc) state_d = DATA;
      DATA:    if (tc && bit_q == 4'd15) state_d = STOP;
      default: if (tc) state_d = IDLE;
    endcase
  end
  // counters and shifter; start is only looked at in IDLE so busy-time requests are dropped
  always_comb begin
    baud_d  = (state_q == IDLE || tc) ? '0 : baud_q + 1'b1;
    bit_d   = state_q != DATA ? 4'd0 : !tc ? bit_q : bit_q == 4'd15 ? 4'd0 : bit_q + 4'd1;
    shift_d = (state_q == IDLE && start) ? data_in : (state_q == DATA && tc) ? {1'b0, shift_q[15:1]} : shift_q;
  end
  // outputs registered from next state so tx/busy change on the same edge as the state
  always_comb begin
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    busy_d = state_d != IDLE;
    done_d = state_q == STOP && tc;
  end
endmodule

// File: tb/tb_port0_serial_tx.sv
// tb_port0_serial_tx: directed checks of framing, pacing, back-to-back, ignore and abort behaviour
module tb_port0_serial_tx;
  logic        clk;
  logic        rst4, start4, tx4, busy4, done4;
  logic [15:0] din4;
  logic        rst1, start1, tx1, busy1, done1;
  logic [15:0] din1;
  int          errors, checks;
  port0_serial_tx #(.CLKS_PER_BIT(4)) u4 (
    .clk(clk), .reset(rst4), .start(start4), .data_in(din4),
    .tx(tx4), .busy(busy4), .done(done4)
  );
  port0_serial_tx #(.CLKS_PER_BIT(1)) u1 (
    .clk(clk), .reset(rst1), .start(start1), .data_in(din1),
    .tx(tx1), .busy(busy1), .done(done1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_frame(input logic [15:0] w, input bit do_start, input bit chain,
                           input logic [15:0] nw, input bit poke);
    logic [15:0] dec;
    logic        exp_tx;
    int          busy_n;
    dec = '0;
    busy_n = 0;
    if (do_start) begin
      start4 = 1'b1;
      din4 = w;
    end
    for (int k = 1; k <= 73; k++) begin
      @(negedge clk);
      if (k == 1) start4 = 1'b0;
      if (poke && k == 20) begin
        start4 = 1'b1;
        din4 = 16'h1234;
      end
      if (poke && k == 21) start4 = 1'b0;
      if (k <= 72) begin
        exp_tx = k <= 4 ? 1'b0 : k > 68 ? 1'b1 : w[(k-5)/4];
        chk("tx_bit", tx4, exp_tx);
        chk("done_low_in_frame", done4, 0);
        busy_n += busy4;
        if (k > 4 && k <= 68 && (k - 5) % 4 == 2) dec[(k-5)/4] = tx4;
      end else begin
        chk("done_pulse", done4, 1);
        chk("busy_after_frame", busy4, 0);
        chk("tx_after_frame", tx4, 1);
        chk("busy_length", busy_n, 72);
        chk("decoded_word", dec, w);
        if (chain) begin
          start4 = 1'b1;
          din4 = nw;
        end
      end
    end
  endtask
  initial begin
    logic [15:0] w1;
    int          n;
    errors = 0;
    checks = 0;
    rst4 = 1'b1; start4 = 1'b0; din4 = '0;
    rst1 = 1'b1; start1 = 1'b0; din1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_tx", tx4, 1);
    chk("reset_busy", busy4, 0);
    chk("reset_done", done4, 0);
    chk("reset_busy_c1", busy1, 0);
    rst4 = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_tx", tx4, 1);
      chk("idle_busy", busy4, 0);
      chk("idle_done", done4, 0);
    end
    run_frame(16'hA5C3, 1'b1, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("idle_after_a5c3", busy4, 0);
    run_frame(16'hFFFF, 1'b1, 1'b1, 16'h0001, 1'b0);
    run_frame(16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0);
    run_frame(16'h00FF, 1'b1, 1'b0, 16'h0000, 1'b1);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n += busy4;
      n += !tx4;
    end
    chk("no_queued_frame", n, 0);
    start4 = 1'b1;
    din4 = 16'hBEEF;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 1) start4 = 1'b0;
    end
    chk("beef_bit7", tx4, 1);
    chk("beef_busy", busy4, 1);
    rst4 = 1'b1;
    @(negedge clk);
    chk("abort_tx", tx4, 1);
    chk("abort_busy", busy4, 0);
    chk("abort_done", done4, 0);
    rst4 = 1'b0;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n += done4;
      n += busy4;
    end
    chk("no_done_after_abort", n, 0);
    run_frame(16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst4 = 1'b1;
    start4 = 1'b1;
    din4 = 16'hFFFF;
    @(negedge clk);
    chk("rst_wins_busy", busy4, 0);
    chk("rst_wins_tx", tx4, 1);
    rst4 = 1'b0;
    start4 = 1'b0;
    @(negedge clk);
    chk("rst_wins_stay_idle", busy4, 0);
    w1 = 16'h8001;
    start1 = 1'b1;
    din1 = w1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (k <= 18) begin
        chk("c1_tx", tx1, k == 1 ? 1'b0 : k == 18 ? 1'b1 : w1[k-2]);
        chk("c1_busy", busy1, 1);
        chk("c1_done_low", done1, 0);
      end else begin
        chk("c1_done", done1, 1);
        chk("c1_busy_end", busy1, 0);
      end
    end
    @(negedge clk);
    chk("c1_done_one_cycle", done1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
